push_conditioner: RTL and testbench
===================================

# push_conditioner

Conditions the five raw push-button inputs (up, down, left, right, middle) before the clock/alarm/stopwatch/mini-game control logic uses them. It sits directly upstream of the top-level control and replaces raw `push` sampling. Per button it performs three steps:
- 2-flop synchronization;
- counter-based debounce;
- single-cycle press detection, plus optional auto-repeat so that holding up/down steps time and alarm fields continuously.

## Interface
Parameters:
- N_BTN, 5, number of buttons. Bit order: 0 up, 1 down, 2 left, 3 right, 4 middle.
- DEBOUNCE_CYCLES, 10000, consecutive cycles a changed input must persist before it is accepted. Must be ≥1.
- REPEAT_DELAY, 500000, cycles from the press pulse to the first repeat pulse. Must be ≥1.
- REPEAT_PERIOD, 100000, cycles between subsequent repeat pulses. Must be ≥1.
- REPEAT_MASK, 5'b00011, buttons allowed to auto-repeat (default: up and down only).

Ports:
- clk_osc  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push_raw  in  N_BTN  raw, asynchronous, bouncy button levels; 1 = pressed.
- btn_level  out  N_BTN  debounced button level.
- btn_press  out  N_BTN  one-cycle pulse on each accepted 0→1 transition.
- btn_repeat  out  N_BTN  one-cycle auto-repeat pulses (masked buttons only).
- btn_event  out  N_BTN  btn_press | btn_repeat; the signal the control logic consumes.

## Operation
- Reset behavior: while rst_n=0, every flop is cleared, including synchronizers, debounce counters, repeat counters and all outputs. Every output is 0 during reset and immediately after it.
- Synchronizer: sync1 <= push_raw, then sync2 <= sync1.
- Debounce, per button:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == btn_level, the counter goes to 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: btn_level <= sync2 and the counter goes to 0.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes btn_level.
- Press: btn_press is registered. It is 1 exactly on the edge where btn_level goes 0→1, and 0 on every other cycle. No pulse on release.
- Auto-repeat applies only to bits set in REPEAT_MASK; unmasked bits hold btn_repeat at 0 permanently. Per-button FSM:
  - IDLE: btn_level=0. On the accepted press edge, go to WAIT with the repeat counter at 0.
  - WAIT: the counter increments each cycle. When the counter reaches REPEAT_DELAY-1, pulse btn_repeat, reset the counter to 0 and go to RPT.
  - RPT: the counter increments each cycle. When it reaches REPEAT_PERIOD-1, pulse btn_repeat and reset the counter to 0.
  - From WAIT or RPT, an accepted release (btn_level 1→0) goes to IDLE immediately. No repeat pulse occurs on that edge; release has priority.
- Buttons are fully independent. Simultaneous presses on several bits produce simultaneous pulses.
- btn_press and btn_repeat are never both 1 on the same bit in the same cycle.
- Reset mid-hold: a button still held when rst_n deasserts is treated as a new press. btn_press fires after the normal latency.

## Timing
- Let edge k be the first rising edge that samples push_raw=1 on a clean press.
  - sync2=1 after edge k+1.
  - btn_level and btn_press go to 1 at edge k+DEBOUNCE_CYCLES+1.
  - btn_press drops at edge k+DEBOUNCE_CYCLES+2.
- Release latency equals press latency, DEBOUNCE_CYCLES+1 edges.
- Let edge P be the press edge. Repeat pulses occur at edges P+REPEAT_DELAY+n·REPEAT_PERIOD, for n ≥ 0, while the button is held.
- btn_event is the combinational OR of two registered outputs and adds no extra latency.
- Input pulses on push_raw shorter than one clock period may be missed. This is acceptable.

## Test plan
All scenarios use overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
1. Reset: hold rst_n=0 with push_raw=5'b11111. All outputs must read 0. Release rst_n at edge R. Then btn_level=5'b11111 and btn_press=5'b11111 for exactly one cycle, at edge R+5.
2. Clean press of bit 2 (left), held 30 cycles: btn_press[2] pulses once, 5 edges after it is first sampled. btn_repeat[2] stays 0 throughout. Release: btn_level[2] falls 5 edges after release is first sampled.
3. Bounce on bit 4: a 0/1/0/1 pattern of 3-cycle highs, then a steady 1. Exactly one btn_press[4], 5 edges after the steady high is first sampled. No pulse during the bounce.
4. Hold bit 0 (up) 60 cycles after press edge P: btn_event[0] pulses at P, P+20, P+28, P+36, P+44, P+52. Release during RPT: btn_repeat[0] is 0 from the release-accept edge onward.
5. Simultaneous press of bits 0 and 1 at the same edge: btn_press=5'b00011 in a single cycle. The repeat pulses on both bits are cycle-aligned.
6. Assert rst_n=0 while bit 1 is in RPT: outputs clear asynchronously, with no clock edge needed. After release, behavior matches scenario 1 for bit 1.

Source files
------------

// File: rtl/push_conditioner.sv
// rtl/push_conditioner.sv - per-button synchronizer, debounce, press pulse and auto-repeat
module push_conditioner #(
    parameter int               N_BTN           = 5,
    parameter int               DEBOUNCE_CYCLES = 10000,
    parameter int               REPEAT_DELAY    = 500000,
    parameter int               REPEAT_PERIOD   = 100000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b00011
) (
    input  logic             clk_osc,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] push_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_event
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RPT  = 2'd2;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk_osc or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= push_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [DW-1:0] r_db_cnt;
        logic          r_level;
        logic          r_press;
        logic          w_changed;
        logic          w_accept;
        logic          w_rise;

        assign w_changed = (r_sync2[i] != r_level);
        assign w_accept  = w_changed && (r_db_cnt == DB_LAST);
        assign w_rise    = w_accept && r_sync2[i];

        always_ff @(posedge clk_osc or negedge rst_n) begin
            if (!rst_n) begin
                r_db_cnt <= '0;
                r_level  <= 1'b0;
                r_press  <= 1'b0;
            end else begin
                r_press <= w_rise;
                if (!w_changed) begin
                    r_db_cnt <= '0;
                end else if (w_accept) begin
                    r_db_cnt <= '0;
                    r_level  <= r_sync2[i];
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        assign btn_level[i] = r_level;
        assign btn_press[i] = r_press;

        if (REPEAT_MASK[i]) begin : g_rpt
            logic [1:0]    r_state;
            logic [RW-1:0] r_rpt_cnt;
            logic          r_repeat;
            logic          w_fall;

            assign w_fall = w_accept && !r_sync2[i];

            // An accepted release wins over a repeat pulse due on the same edge.
            always_ff @(posedge clk_osc or negedge rst_n) begin
                if (!rst_n) begin
                    r_state   <= S_IDLE;
                    r_rpt_cnt <= '0;
                    r_repeat  <= 1'b0;
                end else begin
                    r_repeat <= 1'b0;
                    if (w_fall) begin
                        r_state   <= S_IDLE;
                        r_rpt_cnt <= '0;
                    end else begin
                        case (r_state)
                            S_IDLE: begin
                                r_rpt_cnt <= '0;
                                if (w_rise) r_state <= S_WAIT;
                            end
                            S_WAIT: begin
                                if (r_rpt_cnt == RD_LAST) begin
                                    r_repeat  <= 1'b1;
                                    r_rpt_cnt <= '0;
                                    r_state   <= S_RPT;
                                end else begin
                                    r_rpt_cnt <= r_rpt_cnt + 1'b1;
                                end
                            end
                            S_RPT: begin
                                if (r_rpt_cnt == RP_LAST) begin
                                    r_repeat  <= 1'b1;
                                    r_rpt_cnt <= '0;
                                end else begin
                                    r_rpt_cnt <= r_rpt_cnt + 1'b1;
                                end
                            end
                            default: begin
                                r_state   <= S_IDLE;
                                r_rpt_cnt <= '0;
                            end
                        endcase
                    end
                end
            end

            assign btn_repeat[i] = r_repeat;
        end else begin : g_no_rpt
            assign btn_repeat[i] = 1'b0;
        end
    end

    assign btn_event = btn_press | btn_repeat;

endmodule

// File: tb/tb_push_conditioner.sv
// tb/tb_push_conditioner.sv - directed vector bench for push_conditioner
module tb_push_conditioner;

    logic       clk_osc;
    logic       rst_n;
    logic [4:0] push_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_repeat;
    logic [4:0] btn_event;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] raw;
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rpt;
    } vec_t;

    vec_t tbl[$];

    push_conditioner #(
        .N_BTN          (5),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .REPEAT_MASK    (5'b00011)
    ) dut (
        .clk_osc   (clk_osc),
        .rst_n     (rst_n),
        .push_raw  (push_raw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_repeat(btn_repeat),
        .btn_event (btn_event)
    );

    initial clk_osc = 1'b0;
    always #5 clk_osc = ~clk_osc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] lvl, input logic [4:0] prs,
                           input logic [4:0] rpt);
        chk({tag, " level"},  btn_level,  lvl);
        chk({tag, " press"},  btn_press,  prs);
        chk({tag, " repeat"}, btn_repeat, rpt);
        chk({tag, " event"},  btn_event,  prs | rpt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_osc);
    endtask

    initial begin
        logic [4:0] e_lvl;
        logic [4:0] e_prs;
        logic [4:0] e_rpt;

        // Clean press of left (bit 2), held 30 cycles then released.
        for (int j = 0; j < 40; j++) begin
            vec_t v;
            v.raw = (j < 30) ? 5'b00100 : 5'b00000;
            v.lvl = (j >= 5 && j < 35) ? 5'b00100 : 5'b00000;
            v.prs = (j == 5) ? 5'b00100 : 5'b00000;
            v.rpt = 5'b00000;
            tbl.push_back(v);
        end
        // Bounce on middle (bit 4): 3-cycle highs, then steady high from j=15 to 26.
        for (int j = 0; j < 37; j++) begin
            vec_t v;
            v.raw = ((j >= 3 && j < 6) || (j >= 9 && j < 12) || (j >= 15 && j < 27))
                    ? 5'b10000 : 5'b00000;
            v.lvl = (j >= 20 && j < 32) ? 5'b10000 : 5'b00000;
            v.prs = (j == 20) ? 5'b10000 : 5'b00000;
            v.rpt = 5'b00000;
            tbl.push_back(v);
        end

        // Reset held with all buttons pressed.
        rst_n    = 1'b0;
        push_raw = 5'b11111;
        idle(3);
        chk_all("reset", 5'b00000, 5'b00000, 5'b00000);
        rst_n = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk_osc);
            e_lvl = (j >= 5) ? 5'b11111 : 5'b00000;
            e_prs = (j == 5) ? 5'b11111 : 5'b00000;
            chk_all($sformatf("s1 R+%0d", j), e_lvl, e_prs, 5'b00000);
        end
        push_raw = 5'b00000;
        idle(12);
        chk_all("s1 released", 5'b00000, 5'b00000, 5'b00000);

        for (int j = 0; j < tbl.size(); j++) begin
            push_raw = tbl[j].raw;
            @(negedge clk_osc);
            chk_all($sformatf("tbl[%0d]", j), tbl[j].lvl, tbl[j].prs, tbl[j].rpt);
        end

        // Hold up (bit 0); release accepted on P+68, the edge a repeat would be due.
        push_raw = 5'b00001;
        for (int j = 0; j <= 80; j++) begin
            @(negedge clk_osc);
            e_lvl = (j >= 5 && j < 73) ? 5'b00001 : 5'b00000;
            e_prs = (j == 5) ? 5'b00001 : 5'b00000;
            e_rpt = (j == 25 || j == 33 || j == 41 || j == 49 || j == 57 || j == 65)
                    ? 5'b00001 : 5'b00000;
            chk_all($sformatf("s4 k+%0d", j), e_lvl, e_prs, e_rpt);
            if (j == 67) push_raw = 5'b00000;
        end

        // Simultaneous up and down.
        push_raw = 5'b00011;
        for (int j = 0; j <= 40; j++) begin
            @(negedge clk_osc);
            e_lvl = (j >= 5) ? 5'b00011 : 5'b00000;
            e_prs = (j == 5) ? 5'b00011 : 5'b00000;
            e_rpt = (j == 25 || j == 33) ? 5'b00011 : 5'b00000;
            chk_all($sformatf("s5 k+%0d", j), e_lvl, e_prs, e_rpt);
        end
        push_raw = 5'b00000;
        idle(12);
        chk("s5 released level", btn_level, 5'b00000);

        // Down (bit 1) into RPT, then asynchronous reset between edges.
        push_raw = 5'b00010;
        for (int j = 0; j <= 30; j++) begin
            @(negedge clk_osc);
            e_lvl = (j >= 5) ? 5'b00010 : 5'b00000;
            e_prs = (j == 5) ? 5'b00010 : 5'b00000;
            e_rpt = (j == 25) ? 5'b00010 : 5'b00000;
            chk_all($sformatf("s6 k+%0d", j), e_lvl, e_prs, e_rpt);
        end
        #2 rst_n = 1'b0;
        #1 chk_all("s6 async reset", 5'b00000, 5'b00000, 5'b00000);
        idle(2);
        rst_n = 1'b1;
        for (int j = 0; j <= 26; j++) begin
            @(negedge clk_osc);
            e_lvl = (j >= 5) ? 5'b00010 : 5'b00000;
            e_prs = (j == 5) ? 5'b00010 : 5'b00000;
            e_rpt = (j == 25) ? 5'b00010 : 5'b00000;
            chk_all($sformatf("s6 R+%0d", j), e_lvl, e_prs, e_rpt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
